// File: rtl/noc2nic_vc_tracker_pkg.sv
// Shared NIC constants and VC state encodings for the receive-side VC tracker.
// These mirror the NIC-defines values, so the NoC-to-NIC side and debug logic decode VC state the same way.
package noc2nic_vc_tracker_pkg;

    localparam int N_OF_VC = 4;
    localparam int N_OF_VN = 2;
    localparam int N_VC    = N_OF_VC * N_OF_VN;

    typedef enum logic [1:0] {
        VC_ST_FREE  = 2'd0,
        VC_ST_ALLOC = 2'd1,
        VC_ST_TAIL  = 2'd2
    } vc_state_e;

    function automatic int occ_lsb(input int vc, input int n_bits_cnt);
        return vc * n_bits_cnt;
    endfunction

endpackage

// File: rtl/noc2nic_vc_tracker_if.sv
// Router-write / NIC-pop strobes in and per-VC free/occupancy/error status out.
interface noc2nic_vc_tracker_if
    import noc2nic_vc_tracker_pkg::*;
#(
    parameter int N_VC_P     = N_VC,
    parameter int N_BITS_CNT = 3
);
    logic                         wr_valid_i;
    logic [N_VC_P-1:0]            wr_vc_i;
    logic                         wr_head_i;
    logic                         wr_tail_i;
    logic [N_VC_P-1:0]            rd_i;
    logic [N_VC_P-1:0]            rd_tail_i;
    logic [N_VC_P-1:0]            free_signal_o;
    logic [N_VC_P*N_BITS_CNT-1:0] occupancy_o;
    logic [N_VC_P-1:0]            err_o;

    modport master (
        output wr_valid_i, wr_vc_i, wr_head_i, wr_tail_i, rd_i, rd_tail_i,
        input  free_signal_o, occupancy_o, err_o
    );

    modport slave (
        input  wr_valid_i, wr_vc_i, wr_head_i, wr_tail_i, rd_i, rd_tail_i,
        output free_signal_o, occupancy_o, err_o
    );
endinterface

// File: rtl/noc2nic_vc_tracker_vc_state_entry.sv
// One VC's ownership FSM, occupancy counter and sticky error flag.
// Protocol checking is compiled in only when NOC2NIC_VC_TRACKER_ERR_EN is defined.
module vc_state_entry
    import noc2nic_vc_tracker_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4,
    parameter int N_BITS_CNT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr,
    input  logic                  i_head,
    input  logic                  i_tail,
    input  logic                  i_pop,
    input  logic                  i_pop_tail,
    output logic                  o_free,
    output logic [N_BITS_CNT-1:0] o_count,
    output logic                  o_err
);
    localparam logic [N_BITS_CNT-1:0] LP_DEPTH = N_BITS_CNT'(BUFFER_DEPTH);

    vc_state_e             r_state, w_state_next;
    logic [N_BITS_CNT-1:0] r_count, w_count_next;
    logic                  r_free;
    logic                  w_wr_ok, w_inc, w_dec, w_full, w_empty, w_tail_pop;
`ifdef NOC2NIC_VC_TRACKER_ERR_EN
    logic                  r_err, w_err_set;
`endif

    always_comb begin
        w_full     = (r_count == LP_DEPTH);
        w_empty    = (r_count == '0);
        w_tail_pop = i_pop & i_pop_tail & (r_state == VC_ST_TAIL);
`ifdef NOC2NIC_VC_TRACKER_ERR_EN
        w_wr_ok = i_wr & ~w_full &
                  (i_head ? (r_state == VC_ST_FREE) : (r_state != VC_ST_FREE));
        w_inc   = w_wr_ok;
`else
        // Without checks the FSM trusts every write; only the counter saturates.
        w_wr_ok = i_wr;
        w_inc   = i_wr & ~w_full;
`endif
        w_dec        = i_pop & ~w_empty;
        w_count_next = r_count + N_BITS_CNT'(w_inc) - N_BITS_CNT'(w_dec);

        w_state_next = r_state;
        if (w_tail_pop) begin
            w_state_next = VC_ST_FREE;
        end else if (w_wr_ok) begin
            if (r_state == VC_ST_FREE && i_head)
                w_state_next = i_tail ? VC_ST_TAIL : VC_ST_ALLOC;
            else if (r_state == VC_ST_ALLOC && i_tail)
                w_state_next = VC_ST_TAIL;
        end
`ifdef NOC2NIC_VC_TRACKER_ERR_EN
        w_err_set = (i_wr & ~w_wr_ok) | (i_pop & w_empty) |
                    (i_pop & i_pop_tail & (r_state != VC_ST_TAIL)) |
                    (w_tail_pop & (w_count_next != '0));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= VC_ST_FREE;
            r_count <= '0;
            r_free  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_free  <= (w_state_next == VC_ST_FREE);
        end
    end

`ifdef NOC2NIC_VC_TRACKER_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= r_err | w_err_set;
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_free  = r_free;
    assign o_count = r_count;
endmodule

// File: rtl/noc2nic_vc_tracker.sv
// NIC input-port VC tracker: one vc_state_entry per VC, outputs concatenated.
// Optional protocol checks: define NOC2NIC_VC_TRACKER_ERR_EN.
module noc2nic_vc_tracker
    import noc2nic_vc_tracker_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4,
    parameter int N_BITS_CNT   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    noc2nic_vc_tracker_if.slave  bus
);
    logic [N_VC-1:0]            w_free;
    logic [N_VC-1:0]            w_err;
    logic [N_VC*N_BITS_CNT-1:0] w_occ;

    generate
        for (genvar gi = 0; gi < N_VC; gi++) begin : g_vc
            vc_state_entry #(
                .BUFFER_DEPTH (BUFFER_DEPTH),
                .N_BITS_CNT   (N_BITS_CNT)
            ) u_entry (
                .clk        (clk),
                .rst        (rst),
                .i_wr       (bus.wr_valid_i & bus.wr_vc_i[gi]),
                .i_head     (bus.wr_head_i),
                .i_tail     (bus.wr_tail_i),
                .i_pop      (bus.rd_i[gi]),
                .i_pop_tail (bus.rd_tail_i[gi]),
                .o_free     (w_free[gi]),
                .o_count    (w_occ[gi*N_BITS_CNT +: N_BITS_CNT]),
                .o_err      (w_err[gi])
            );
        end
    endgenerate

    assign bus.free_signal_o = w_free;
    assign bus.occupancy_o   = w_occ;
    assign bus.err_o         = w_err;
endmodule

// File: tb/tb_noc2nic_vc_tracker.sv
// Directed test-plan scenarios followed by randomized traffic checked against a per-VC packet model.
module tb_noc2nic_vc_tracker;
    import noc2nic_vc_tracker_pkg::*;

    localparam int DEPTH = 4;
    localparam int NB    = 3;
`ifdef NOC2NIC_VC_TRACKER_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif
    localparam int M_FREE = 0, M_OPEN = 1, M_DONE = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc2nic_vc_tracker_if #(.N_VC_P(N_VC), .N_BITS_CNT(NB)) bus();

    noc2nic_vc_tracker #(.BUFFER_DEPTH(DEPTH), .N_BITS_CNT(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int m_st  [N_VC];
    int m_cnt [N_VC];
    bit m_err [N_VC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_VC; i++) begin
            m_st[i] = M_FREE; m_cnt[i] = 0; m_err[i] = 1'b0;
        end
    endfunction

    // Packet-level rules: which writes a VC may accept, how many flits it holds, when it is released.
    function automatic void model_step();
        for (int i = 0; i < N_VC; i++) begin
            bit w, p, pt, hdr_ok, accept;
            int nc;
            w  = bus.wr_valid_i && bus.wr_vc_i[i];
            p  = bus.rd_i[i];
            pt = p && bus.rd_tail_i[i];
            hdr_ok = bus.wr_head_i ? (m_st[i] == M_FREE) : (m_st[i] != M_FREE);
            accept = ERR_ON ? (w && hdr_ok && m_cnt[i] < DEPTH) : w;
            nc = m_cnt[i];
            if (accept && m_cnt[i] < DEPTH) nc++;
            if (p && m_cnt[i] > 0) nc--;
            if (ERR_ON) begin
                if (w && !accept) m_err[i] = 1'b1;
                if (p && m_cnt[i] == 0) m_err[i] = 1'b1;
                if (pt && m_st[i] != M_DONE) m_err[i] = 1'b1;
            end
            if (pt && m_st[i] == M_DONE) begin
                m_st[i] = M_FREE;
                if (ERR_ON && nc != 0) m_err[i] = 1'b1;
            end else if (accept) begin
                if (m_st[i] == M_FREE && bus.wr_head_i)
                    m_st[i] = bus.wr_tail_i ? M_DONE : M_OPEN;
                else if (m_st[i] == M_OPEN && bus.wr_tail_i)
                    m_st[i] = M_DONE;
            end
            m_cnt[i] = nc;
        end
    endfunction

    function automatic logic [31:0] exp_free();
        logic [31:0] v = '0;
        for (int i = 0; i < N_VC; i++) v[i] = (m_st[i] == M_FREE);
        return v;
    endfunction

    function automatic logic [31:0] exp_occ();
        logic [31:0] v = '0;
        for (int i = 0; i < N_VC; i++) v[i*NB +: NB] = NB'(m_cnt[i]);
        return v;
    endfunction

    function automatic logic [31:0] exp_err();
        logic [31:0] v = '0;
        for (int i = 0; i < N_VC; i++) v[i] = m_err[i];
        return v;
    endfunction

    task automatic clear_in();
        bus.wr_valid_i = 1'b0; bus.wr_vc_i = '0; bus.wr_head_i = 1'b0;
        bus.wr_tail_i = 1'b0;  bus.rd_i = '0;    bus.rd_tail_i = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_step();
        $display("t=%0t rst=%b wr=%b vc=%h h=%b t=%b rd=%h rdt=%h | free=%h occ=%h err=%h",
                 $time, rst, bus.wr_valid_i, bus.wr_vc_i, bus.wr_head_i, bus.wr_tail_i,
                 bus.rd_i, bus.rd_tail_i, bus.free_signal_o, bus.occupancy_o, bus.err_o);
        chk("free_vec", 32'(bus.free_signal_o), exp_free());
        chk("occ_vec",  32'(bus.occupancy_o),   exp_occ());
        chk("err_vec",  32'(bus.err_o),         exp_err());
    endtask

    task automatic wr(input int vc, input bit h, input bit t);
        clear_in();
        bus.wr_valid_i = 1'b1; bus.wr_vc_i = N_VC'(1) << vc;
        bus.wr_head_i = h; bus.wr_tail_i = t;
        cycle();
        clear_in();
    endtask

    task automatic pop(input int vc, input bit t);
        clear_in();
        bus.rd_i[vc] = 1'b1; bus.rd_tail_i[vc] = t;
        cycle();
        clear_in();
    endtask

    function automatic logic [NB-1:0] occ_of(input int vc);
        return bus.occupancy_o[vc*NB +: NB];
    endfunction

    initial begin
        clear_in();
        model_reset();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        repeat (3) cycle();
        chk("rst_free", 32'(bus.free_signal_o), 32'hFF);
        chk("rst_occ",  32'(bus.occupancy_o),   32'h0);
        chk("rst_err",  32'(bus.err_o),         32'h0);

        // Three-flit packet on VC0, then drained with the tail marked on the last pop.
        wr(0, 1, 0);
        chk("vc0_free_after_head", 32'(bus.free_signal_o[0]), 32'd0);
        wr(0, 0, 0);
        wr(0, 0, 1);
        chk("vc0_occ3", 32'(occ_of(0)), 32'd3);
        pop(0, 0);
        pop(0, 0);
        chk("vc0_still_busy", 32'(bus.free_signal_o[0]), 32'd0);
        pop(0, 1);
        chk("vc0_occ0", 32'(occ_of(0)), 32'd0);
        chk("vc0_freed", 32'(bus.free_signal_o[0]), 32'd1);

        // Single-flit packet: two-cycle turnaround on VC5.
        wr(5, 1, 1);
        chk("vc5_busy", 32'(bus.free_signal_o), 32'hDF);
        pop(5, 1);
        chk("vc5_free", 32'(bus.free_signal_o), 32'hFF);

        // Simultaneous write and pop on VC2 at count 2.
        wr(2, 1, 0);
        wr(2, 0, 0);
        clear_in();
        bus.wr_valid_i = 1'b1; bus.wr_vc_i = N_VC'(1) << 2; bus.rd_i[2] = 1'b1;
        cycle();
        clear_in();
        chk("vc2_occ_hold", 32'(occ_of(2)), 32'd2);
        chk("vc2_no_err", 32'(bus.err_o[2]), 32'd0);

        // Five writes into a depth-4 buffer on VC1.
        wr(1, 1, 0);
        repeat (4) wr(1, 0, 0);
        chk("vc1_sat", 32'(occ_of(1)), 32'd4);
        chk("vc1_ovf_err", 32'(bus.err_o[1]), ERR_ON ? 32'd1 : 32'd0);

        // Head write into an open packet on VC3, then a mid-packet reset.
        wr(3, 1, 0);
        wr(3, 0, 0);
        wr(3, 1, 0);
        chk("vc3_occ", 32'(occ_of(3)), ERR_ON ? 32'd2 : 32'd3);
        chk("vc3_err", 32'(bus.err_o[3]), ERR_ON ? 32'd1 : 32'd0);
        chk("vc3_busy", 32'(bus.free_signal_o[3]), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_free", 32'(bus.free_signal_o), 32'hFF);
        chk("mid_rst_occ",  32'(bus.occupancy_o),   32'h0);
        chk("mid_rst_err",  32'(bus.err_o),         32'h0);

        // Random traffic, mostly protocol-respecting, with occasional violations and resets.
        for (int c = 0; c < 400; c++) begin
            clear_in();
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) != 0) begin
                int v = $urandom_range(0, N_VC - 1);
                bus.wr_valid_i = 1'b1;
                bus.wr_vc_i = ($urandom_range(0, 19) == 0) ? '0 : (N_VC'(1) << v);
                if (m_st[v] == M_FREE) begin
                    bus.wr_head_i = ($urandom_range(0, 9) != 0);
                    bus.wr_tail_i = ($urandom_range(0, 2) == 0);
                end else if (m_st[v] == M_OPEN) begin
                    bus.wr_head_i = ($urandom_range(0, 9) == 0);
                    bus.wr_tail_i = ($urandom_range(0, 3) == 0);
                end else begin
                    bus.wr_head_i = ($urandom_range(0, 9) == 0);
                    bus.wr_tail_i = 1'b0;
                end
            end
            for (int i = 0; i < N_VC; i++) begin
                if (m_cnt[i] > 0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0)) begin
                    bus.rd_i[i] = 1'b1;
                    bus.rd_tail_i[i] = (m_st[i] == M_DONE && m_cnt[i] == 1) ? 1'b1
                                       : ($urandom_range(0, 29) == 0);
                end
            end
            cycle();
        end
        rst = 1'b0;
        clear_in();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
